// File: rtl/pm1_pkg.sv
// Shared state encoding, width defaults and modular helper for the Pollard p-1 stage-1 sequencer.
package pm1_pkg;

  localparam int DEF_N_W = 100;
  localparam int DEF_E_W = 8;
  localparam int DEF_B_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EXP,
    ST_GCD,
    ST_DONE
  } pm1_state_e;

  // x - 1 mod n for a residue x already in [0, n)
  function automatic logic [DEF_N_W-1:0] dec_mod(input logic [DEF_N_W-1:0] x,
                                                 input logic [DEF_N_W-1:0] n);
    return (x == '0) ? n - DEF_N_W'(1) : x - DEF_N_W'(1);
  endfunction

endpackage

// File: rtl/pm1_stage1_sched.sv
// Pollard p-1 stage-1 sequencer: walks a_k = a_(k-1)^k mod n, then checks gcd(a_k - 1, n).
// Define PM1_PERIODIC_GCD_EN to check the GCD after every step and exit early on a factor.
module pm1_stage1_sched
  import pm1_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int E_W = DEF_E_W,
  parameter int B_W = DEF_B_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] n,
  input  logic [B_W-1:0] base,
  input  logic [E_W-1:0] bound,
  output logic           exp_req,
  output logic [N_W-1:0] exp_base,
  output logic [E_W-1:0] exp_exponent,
  input  logic           exp_done,
  input  logic [N_W-1:0] exp_result,
  output logic           gcd_req,
  output logic [N_W-1:0] gcd_a,
  output logic [N_W-1:0] gcd_b,
  input  logic           gcd_done,
  input  logic [N_W-1:0] gcd_result,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [N_W-1:0] factor,
  output logic [E_W-1:0] iter
);

  pm1_state_e state, state_nxt;

  logic [N_W-1:0] n_q, res_q, factor_q;
  logic [E_W-1:0] bound_q, k_q, iter_q;
  logic           exp_req_q, gcd_req_q, done_q, found_q;
  logic           exp_fire, gcd_fire, last_k, g_hit, run_start;

  // done pulses are only honoured while the matching request is up
  assign exp_fire  = exp_req_q & exp_done;
  assign gcd_fire  = gcd_req_q & gcd_done;
  assign last_k    = (k_q == bound_q);
  assign g_hit     = (gcd_result > N_W'(1)) && (gcd_result < n_q);
  assign run_start = start & ((state == ST_IDLE) || (state == ST_DONE));

`ifdef PM1_PERIODIC_GCD_EN
  logic g_full;
  assign g_full = (gcd_result == n_q);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (run_start) state_nxt = ST_CHECK;
        ST_CHECK:         state_nxt = (bound_q < E_W'(2)) ? ST_DONE : ST_EXP;
        ST_EXP: begin
`ifdef PM1_PERIODIC_GCD_EN
          if (exp_fire) state_nxt = ST_GCD;
`else
          if (exp_fire && last_k) state_nxt = ST_GCD;
`endif
        end
        ST_GCD: begin
`ifdef PM1_PERIODIC_GCD_EN
          if (gcd_fire) state_nxt = (g_hit || g_full || last_k) ? ST_DONE : ST_EXP;
`else
          if (gcd_fire) state_nxt = ST_DONE;
`endif
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q       <= '0;
      res_q     <= '0;
      bound_q   <= '0;
      k_q       <= '0;
      iter_q    <= '0;
      factor_q  <= '0;
      exp_req_q <= 1'b0;
      gcd_req_q <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
    end else if (abort) begin
      exp_req_q <= 1'b0;
      gcd_req_q <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      factor_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (run_start) begin
            n_q      <= n;
            res_q    <= N_W'(base);
            bound_q  <= bound;
            k_q      <= E_W'(2);
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            factor_q <= '0;
          end
        end
        ST_CHECK: if (bound_q < E_W'(2)) done_q <= 1'b1;
        ST_EXP: begin
          // request drops for one cycle after every completion
          if (exp_fire) begin
            res_q     <= exp_result;
            iter_q    <= k_q;
            exp_req_q <= 1'b0;
`ifndef PM1_PERIODIC_GCD_EN
            if (!last_k) k_q <= k_q + E_W'(1);
`endif
          end else begin
            exp_req_q <= 1'b1;
          end
        end
        ST_GCD: begin
          if (gcd_fire) begin
            gcd_req_q <= 1'b0;
            found_q   <= g_hit;
            factor_q  <= g_hit ? gcd_result : '0;
`ifdef PM1_PERIODIC_GCD_EN
            if (g_hit || g_full || last_k) done_q <= 1'b1;
            else                           k_q    <= k_q + E_W'(1);
`else
            done_q    <= 1'b1;
`endif
          end else begin
            gcd_req_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign exp_req      = exp_req_q;
  assign exp_base     = res_q;
  assign exp_exponent = k_q;
  assign gcd_req      = gcd_req_q;
  assign gcd_a        = gcd_req_q ? N_W'(dec_mod(DEF_N_W'(res_q), DEF_N_W'(n_q))) : '0;
  assign gcd_b        = gcd_req_q ? n_q : '0;
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign done         = done_q;
  assign found        = found_q;
  assign factor       = factor_q;
  assign iter         = iter_q;

endmodule

// File: tb/tb_pm1_stage1_sched.sv
// Directed bench for pm1_stage1_sched: random-latency modexp/GCD responders and a request scoreboard.
module tb_pm1_stage1_sched;

  localparam int N_W = 100;
  localparam int E_W = 8;
  localparam int B_W = 9;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [N_W-1:0] n = '0;
  logic [B_W-1:0] base = '0;
  logic [E_W-1:0] bound = '0;
  logic           exp_req, gcd_req, busy, done, found;
  logic [N_W-1:0] exp_base, gcd_a, gcd_b, factor;
  logic [E_W-1:0] exp_exponent, iter;
  logic           exp_done, gcd_done;
  logic [N_W-1:0] exp_result, gcd_result;

  int     total = 0;
  int     bad = 0;
  int     nexp = 0;
  int     ngcd = 0;
  int     hold_k = 0;
  longint cur_n = 0;
  longint eq_base[$];
  longint eq_k[$];
  longint gq_a[$];

  always #5 clk = ~clk;

  pm1_stage1_sched #(.N_W(N_W), .E_W(E_W), .B_W(B_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .n(n), .base(base), .bound(bound),
    .exp_req(exp_req), .exp_base(exp_base), .exp_exponent(exp_exponent),
    .exp_done(exp_done), .exp_result(exp_result),
    .gcd_req(gcd_req), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .busy(busy), .done(done), .found(found), .factor(factor), .iter(iter)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint modpow(input longint b, input longint e, input longint m);
    longint r, bb, ee;
    if (m <= 0) return 0;
    r = 1 % m; bb = b % m; ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic longint gcd_f(input longint a, input longint b);
    longint x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // modexp unit: random 1..20 cycle latency; exponent hold_k is never answered
  initial begin
    logic   eprev, ebusy, ehold, late_pend;
    longint ebase, ek;
    int     elat;
    eprev = 0; ebusy = 0; ehold = 0; late_pend = 0; elat = 0; ebase = 0; ek = 0;
    exp_done = 1'b0; exp_result = '0;
    forever begin
      @(negedge clk);
      exp_done = 1'b0;
      if (!reset_n) begin
        eprev = 0; ebusy = 0; ehold = 0; late_pend = 0;
      end else begin
        if (late_pend) begin
          exp_done = 1'b1; exp_result = '1; late_pend = 0;
        end else if (ebusy) begin
          elat--;
          if (elat <= 0) begin
            exp_done = 1'b1; exp_result = N_W'(modpow(ebase, ek, cur_n)); ebusy = 0;
          end
        end else if (ehold) begin
          if (abort) begin late_pend = 1; ehold = 0; end
        end else if (exp_req && !eprev) begin
          nexp++;
          chk("exp_sb_pending", 128'(eq_k.size() > 0), 128'(1));
          if (eq_k.size() > 0) begin
            chk("exp_base", 128'(exp_base), 128'(eq_base.pop_front()));
            chk("exp_k", 128'(exp_exponent), 128'(eq_k.pop_front()));
          end
          ebase = exp_base[63:0];
          ek = 64'(exp_exponent);
          if (int'(exp_exponent) == hold_k) ehold = 1;
          else begin ebusy = 1; elat = int'($urandom_range(1, 20)); end
        end
        eprev = exp_req;
      end
    end
  end

  // GCD unit: random 1..20 cycle latency
  initial begin
    logic   gprev, gbusy;
    longint ga, gb;
    int     glat;
    gprev = 0; gbusy = 0; glat = 0; ga = 0; gb = 0;
    gcd_done = 1'b0; gcd_result = '0;
    forever begin
      @(negedge clk);
      gcd_done = 1'b0;
      if (!reset_n) begin
        gprev = 0; gbusy = 0;
      end else begin
        if (gbusy) begin
          glat--;
          if (glat <= 0) begin
            gcd_done = 1'b1; gcd_result = N_W'(gcd_f(ga, gb)); gbusy = 0;
          end
        end else if (gcd_req && !gprev) begin
          ngcd++;
          chk("gcd_sb_pending", 128'(gq_a.size() > 0), 128'(1));
          if (gq_a.size() > 0) chk("gcd_a", 128'(gcd_a), 128'(gq_a.pop_front()));
          chk("gcd_b", 128'(gcd_b), 128'(cur_n));
          ga = gcd_a[63:0]; gb = gcd_b[63:0];
          gbusy = 1; glat = int'($urandom_range(1, 20));
        end
        gprev = gcd_req;
      end
    end
  end

  // reference walk: fills the request scoreboard and returns the expected outcome
  task automatic model(input longint nn, input longint b, input int bnd,
                       output logic f, output longint fac, output int it,
                       output int ne, output int ng);
    longint a, d, g;
    a = b; f = 0; fac = 0; it = -1; ne = 0; ng = 0;
    eq_base.delete(); eq_k.delete(); gq_a.delete();
    if (bnd >= 2) begin
      for (int k = 2; k <= bnd; k++) begin
        eq_base.push_back(a); eq_k.push_back(longint'(k)); ne++;
        a = modpow(a, longint'(k), nn); it = k;
`ifdef PM1_PERIODIC_GCD_EN
        d = (a == 0) ? nn - 1 : a - 1;
        gq_a.push_back(d); ng++;
        g = gcd_f(d, nn);
        if (g > 1 && g < nn) begin f = 1; fac = g; break; end
        if (g == nn) break;
`endif
      end
`ifndef PM1_PERIODIC_GCD_EN
      d = (a == 0) ? nn - 1 : a - 1;
      gq_a.push_back(d); ng++;
      g = gcd_f(d, nn);
      f = (g > 1 && g < nn);
      fac = f ? g : 0;
`endif
    end
  endtask

  task automatic pulse_start(input longint nn, input longint b, input int bnd);
    @(negedge clk); #1;
    n = N_W'(nn); base = B_W'(b); bound = E_W'(bnd); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 4000) begin @(negedge clk); c++; end
    chk({nm, "_done"}, 128'(done), 128'(1));
  endtask

  task automatic run_case(input string nm, input longint nn, input longint b,
                          input int bnd, input bit poke);
    logic   f;
    longint fac;
    int     it, ne, ng, e0, g0;
    model(nn, b, bnd, f, fac, it, ne, ng);
    cur_n = nn; e0 = nexp; g0 = ngcd;
    pulse_start(nn, b, bnd);
    if (poke) begin
      repeat (3) @(negedge clk);
      #1 n = N_W'(15); base = B_W'(3); bound = E_W'(2); start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
    end
    wait_done(nm);
    chk({nm, "_found"}, 128'(found), 128'(f));
    chk({nm, "_factor"}, 128'(factor), 128'(fac));
    if (it >= 0) chk({nm, "_iter"}, 128'(iter), 128'(it));
    chk({nm, "_nexp"}, 128'(nexp - e0), 128'(ne));
    chk({nm, "_ngcd"}, 128'(ngcd - g0), 128'(ng));
    chk({nm, "_sb_left"}, 128'(eq_k.size() + gq_a.size()), 128'(0));
    chk({nm, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    logic   f;
    longint fac;
    int     it, ne, ng, c, e0, g0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 128'({exp_req, gcd_req, busy, done, found}), 128'(0));
    chk("rst_factor", 128'(factor), 128'(0));
    chk("rst_iter", 128'(iter), 128'(0));
    chk("rst_exp_ops", 128'({exp_base, exp_exponent}), 128'(0));
    chk("rst_gcd_ops", 128'({gcd_a, gcd_b}), 128'(0));
    #1 reset_n = 1'b1;

    // batched runs on 299 = 13 x 23
    run_case("b5", 299, 2, 5, 1'b0);
`ifndef PM1_PERIODIC_GCD_EN
    chk("b5_plan_factor", 128'(factor), 128'(13));
    chk("b5_plan_iter", 128'(iter), 128'(5));
`endif
    run_case("b12", 299, 2, 12, 1'b0);
    run_case("b20", 299, 2, 20, 1'b0);
`ifdef PM1_PERIODIC_GCD_EN
    chk("p20_plan_factor", 128'(factor), 128'(13));
    chk("p20_plan_iter", 128'(iter), 128'(4));
`endif

    // bound < 2: done exactly two edges after start, no unit requests
    e0 = nexp; g0 = ngcd; cur_n = 15;
    model(15, 2, 1, f, fac, it, ne, ng);
    pulse_start(15, 2, 1);
    chk("b1_busy", 128'(busy), 128'(1));
    chk("b1_done_early", 128'(done), 128'(0));
    @(negedge clk);
    chk("b1_done", 128'(done), 128'(1));
    chk("b1_found", 128'({found, factor}), 128'(0));
    repeat (3) @(negedge clk);
    chk("b1_no_reqs", 128'((nexp - e0) + (ngcd - g0)), 128'(0));

    // abort while the k=3 request is outstanding, late exp_done follows
    hold_k = 3; cur_n = 299;
    model(299, 2, 12, f, fac, it, ne, ng);
    pulse_start(299, 2, 12);
    c = 0;
    while (!(exp_req === 1'b1 && exp_exponent == E_W'(3)) && c < 2000) begin
      @(negedge clk); c++;
    end
    chk("ab_reach_k3", 128'({exp_req, exp_exponent}), 128'({1'b1, 8'd3}));
    #1 abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;
    chk("ab_idle", 128'({busy, done, exp_req, gcd_req}), 128'(0));
    repeat (2) @(negedge clk);
    #1;
    chk("ab_late_ignored", 128'({busy, done, exp_req, found}), 128'(0));
    chk("ab_iter", 128'(iter), 128'(2));
    hold_k = 0;
    run_case("rerun", 299, 2, 5, 1'b0);

    // start while busy must not disturb the latched operands
    run_case("poke", 299, 2, 5, 1'b1);

    // asynchronous reset in the middle of a GCD
    model(299, 2, 5, f, fac, it, ne, ng);
    cur_n = 299;
    pulse_start(299, 2, 5);
    c = 0;
    while (gcd_req !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
    chk("rg_in_gcd", 128'(gcd_req), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("rg_ctl", 128'({exp_req, gcd_req, busy, done, found}), 128'(0));
    chk("rg_data", 128'({factor, iter, exp_exponent}), 128'(0));
    chk("rg_gcd_ops", 128'({gcd_a, gcd_b}), 128'(0));
    @(negedge clk); #1 reset_n = 1'b1;

    run_case("post_rst", 299, 3, 9, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
